// File: rtl/life_col_reader.sv
// life_col_reader: scans every column of the Life array once per frame and
// streams each column's alive bits over a valid/ready link. Generation
// stepping (gen_enable) is held off for the whole scan so the frame is
// coherent.
// Optional feature macro: LIFE_READ_DIFF_EN adds col_prev/out_diff so each
// streamed column also carries the cells that changed since the previous
// generation.
module life_col_reader #(
    parameter int COLS = 8,
    parameter int ROWS = 4,
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            start,
    output logic            gen_enable,
    output logic [CW-1:0]   col_sel,
    input  logic [ROWS-1:0] col_data,
`ifdef LIFE_READ_DIFF_EN
    input  logic [ROWS-1:0] col_prev,
    output logic [ROWS-1:0] out_diff,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ROWS-1:0] out_data,
    output logic [CW-1:0]   out_col,
    output logic            out_last,
    output logic            busy,
    output logic            frame_done
);

    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FREEZE,
        SELECT,
        SEND,
        DONE
    } state_t;

    state_t state;

    // Scan sequencer: freezes stepping, walks col_sel across the array and
    // holds each captured column on the link until downstream accepts it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            gen_enable <= 1'b0;
            col_sel    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef LIFE_READ_DIFF_EN
            out_diff   <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    gen_enable <= run;
                    if (start) begin
                        gen_enable <= 1'b0;
                        col_sel    <= '0;
                        busy       <= 1'b1;
                        state      <= FREEZE;
                    end
                end
                FREEZE: begin
                    state <= SELECT;
                end
                SELECT: begin
                    out_data  <= col_data;
                    out_col   <= col_sel;
                    out_valid <= 1'b1;
                    out_last  <= (col_sel == LAST_COL);
`ifdef LIFE_READ_DIFF_EN
                    out_diff  <= col_data ^ col_prev;
`endif
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (col_sel == LAST_COL) begin
                            out_last   <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            col_sel <= col_sel + 1'b1;
                            state   <= SELECT;
                        end
                    end
                end
                DONE: begin
                    busy       <= 1'b0;
                    gen_enable <= run;
                    col_sel    <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
